req_group_decoder: RTL and testbench
====================================

Name: req_group_decoder

Overview:
- Responder on the arbiter's group request interface (req_sel/req_addr/req_write/req_wdata in; req_ready/req_rdata out).
- Decodes the upper address bits into one of GRP_NUM register groups.
- Drives that group with an APB3-style setup/access sequence, waits for the group's ready, and returns read data to the arbiter.
- Completes unmapped and hung accesses itself, so the arbiter never stalls.

Parameters:
- ADDR_WIDTH, 21, width of req_addr.
- DATA_WIDTH, 16, data width.
- SEL_WIDTH, 5, group-index field width = req_addr[ADDR_WIDTH-1 -: SEL_WIDTH].
- GRP_NUM, 4, number of mapped groups (indices 0..GRP_NUM-1); GRP_NUM <= 2**SEL_WIDTH.
- WAIT_MAX, 64, maximum ACCESS cycles before forced completion.
- ERR_RDATA, 16'hDEAD, read data returned on unmapped or timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_addr  in  ADDR_WIDTH  request address (stable while req_sel=1)
- req_write  in  1  1=write, 0=read
- req_sel  in  1  request active
- req_wdata  in  DATA_WIDTH  write data
- req_ready  out  1  one-cycle completion pulse
- req_rdata  out  DATA_WIDTH  read data, valid with req_ready
- grp_sel  out  GRP_NUM  one-hot group select (APB psel)
- grp_enable  out  1  APB penable
- grp_addr  out  ADDR_WIDTH-SEL_WIDTH  local address (low bits)
- grp_write  out  1  APB pwrite
- grp_wdata  out  DATA_WIDTH  APB pwdata
- grp_ready  in  GRP_NUM  per-group pready
- grp_rdata  in  GRP_NUM*DATA_WIDTH  per-group prdata, group i at [i*DATA_WIDTH +: DATA_WIDTH]
- err_unmapped  out  1  one-cycle pulse on unmapped access
- err_timeout  out  1  one-cycle pulse on WAIT_MAX expiry

Behaviour:
- Reset (asynchronous, rstn=0): FSM=IDLE; all outputs 0 (req_ready, req_rdata, grp_sel, grp_enable, grp_addr, grp_write, grp_wdata, err_*); wait counter 0. Reset mid-transfer abandons it with no response.
- All outputs are registered; no input-to-output combinational path.
- FSM states: IDLE, SETUP, ACCESS, RESP, DRAIN.
- IDLE, req_sel=1:
  - Latch addr, write, wdata and group index.
  - Index < GRP_NUM: go to SETUP.
  - Otherwise: go to RESP with rdata=ERR_RDATA and err_unmapped pulsed in that RESP cycle.
- SETUP (1 cycle): grp_sel[idx]=1, grp_enable=0, grp_addr/write/wdata driven from latches; go to ACCESS.
- ACCESS: grp_sel[idx]=1, grp_enable=1; wait counter increments each cycle.
  - grp_ready[idx]=1: capture grp_rdata slice (writes capture it too; don't-care) and go to RESP.
  - Counter reaches WAIT_MAX-1 without ready: rdata=ERR_RDATA, err_timeout pulse, go to RESP.
  - Ready on the expiry cycle takes priority: normal completion, no error.
- RESP (1 cycle): req_ready=1, req_rdata=captured; grp_sel/grp_enable=0.
  - Next state is DRAIN if req_sel=1 at this edge, else IDLE.
- DRAIN: wait for req_sel=0, then go to IDLE. This prevents double-servicing one request.
- req_rdata holds its last value until the next RESP.
- Latency with zero-wait group: req_sel seen in IDLE at cycle T; SETUP T+1; ACCESS T+2 (ready); req_ready at T+3. Unmapped: req_ready at T+1.
- req_sel dropped in SETUP or ACCESS (arbiter abort):
  - The group transfer is completed anyway: stay in ACCESS until ready or timeout.
  - The response is suppressed (req_ready stays 0, err_timeout still pulses) and the FSM goes to IDLE.
- Any grp_ready bit other than idx is ignored. Unknown state encoding recovers to IDLE with all outputs 0.
- Wait counter width is clog2(WAIT_MAX)+1 bits; cleared on ACCESS entry; never wraps.

Decomposition:
- Shared package ctrl_sys_pkg:
  - FSM state localparams (one-hot, 5 bits).
  - Default ERR_RDATA.
  - Helper constant for wait-counter width.
- One natural sub-module, req_wait_timer: clear/enable/expire counter parameterised by WAIT_MAX. Address decode stays inline.

Test Plan:
- Read group 2, addr 21'h02_0034, grp_ready[2] asserted the first ACCESS cycle with rdata 16'h1234 -> grp_addr=16'h0034, grp_sel=4'b0100, req_ready pulse at T+3 with req_rdata=16'h1234, no err.
- Write group 0, addr 21'h00_0010, wdata 16'hA5A5, grp_ready after 3 wait cycles -> grp_write=1, grp_wdata=16'hA5A5 held through ACCESS, req_ready at T+6.
- Unmapped addr 21'h1F_0000 -> no grp_sel, req_ready and err_unmapped at T+1, req_rdata=16'hDEAD.
- Group 1 never ready, WAIT_MAX=64 -> exactly 64 ACCESS cycles, then err_timeout and req_ready together with req_rdata=16'hDEAD, grp_sel back to 0.
- req_sel held high for 3 cycles after req_ready -> FSM stays in DRAIN, no second grp_sel; a new request after req_sel low is serviced normally.
- rstn pulled low during ACCESS of group 3 -> all outputs 0 immediately; after release, a read of group 3 completes normally.

Source files
------------

// File: rtl/ctrl_sys_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_sys_pkg
//  Description : Shared constants for the group request decoder slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_sys_pkg;

    localparam logic [4:0] c_st_idle   = 5'b00001;
    localparam logic [4:0] c_st_setup  = 5'b00010;
    localparam logic [4:0] c_st_access = 5'b00100;
    localparam logic [4:0] c_st_resp   = 5'b01000;
    localparam logic [4:0] c_st_drain  = 5'b10000;

    localparam logic [15:0] c_err_rdata_default = 16'hDEAD;

    // One spare bit so the counter can hold WAIT_MAX-1 for any WAIT_MAX
    function automatic int wait_cnt_width(input int wait_max);
        return $clog2(wait_max) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/req_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : req_wait_timer
//  Description : Saturating wait counter with clear/enable and expiry flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_wait_timer
    import ctrl_sys_pkg::*;
#(
    parameter int WAIT_MAX = 64,
    parameter int CNT_W    = wait_cnt_width(64)
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != c_LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expire = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/req_group_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : req_group_decoder
//  Description : Decodes arbiter requests onto APB-style register groups.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_group_decoder
    import ctrl_sys_pkg::*;
#(
    parameter int                   ADDR_WIDTH = 21,
    parameter int                   DATA_WIDTH = 16,
    parameter int                   SEL_WIDTH  = 5,
    parameter int                   GRP_NUM    = 4,
    parameter int                   WAIT_MAX   = 64,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(c_err_rdata_default)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic                            req_write,
    input  logic                            req_sel,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    output logic                            req_ready,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    output logic [GRP_NUM-1:0]              grp_sel,
    output logic                            grp_enable,
    output logic [ADDR_WIDTH-SEL_WIDTH-1:0] grp_addr,
    output logic                            grp_write,
    output logic [DATA_WIDTH-1:0]           grp_wdata,
    input  logic [GRP_NUM-1:0]              grp_ready,
    input  logic [GRP_NUM*DATA_WIDTH-1:0]   grp_rdata,
    output logic                            err_unmapped,
    output logic                            err_timeout
);

    localparam int c_LOC_W = ADDR_WIDTH - SEL_WIDTH;
    localparam int c_CNT_W = wait_cnt_width(WAIT_MAX);

    logic [4:0]            r_state;
    logic [4:0]            w_next;
    logic                  w_bad_state;
    logic [GRP_NUM-1:0]    r_onehot;
    logic                  r_abort;
    logic [SEL_WIDTH-1:0]  w_req_idx;
    logic [GRP_NUM-1:0]    w_dec;
    logic                  w_mapped;
    logic [GRP_NUM-1:0]    w_sel_src;
    logic                  w_grp_ready;
    logic [DATA_WIDTH-1:0] w_grp_rdata;
    logic [DATA_WIDTH-1:0] w_resp_data;
    logic                  w_expire;
    logic                  w_in_access;

    assign w_req_idx   = req_addr[ADDR_WIDTH-1 -: SEL_WIDTH];
    assign w_in_access = (r_state == c_st_access);

    for (genvar gi = 0; gi < GRP_NUM; gi++) begin : g_dec
        assign w_dec[gi] = (w_req_idx == SEL_WIDTH'(gi));
    end

    assign w_mapped    = |w_dec;
    assign w_sel_src   = (r_state == c_st_idle) ? w_dec : r_onehot;
    assign w_grp_ready = |(grp_ready & r_onehot);

    always_comb begin
        w_grp_rdata = '0;
        for (int i = 0; i < GRP_NUM; i++) begin
            if (r_onehot[i]) begin
                w_grp_rdata = w_grp_rdata | grp_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only a ready completion returns group data; unmapped and timeout return ERR_RDATA
    assign w_resp_data = (w_in_access && w_grp_ready) ? w_grp_rdata : ERR_RDATA;

    always_comb begin
        w_next      = r_state;
        w_bad_state = 1'b0;
        case (r_state)
            c_st_idle:   if (req_sel) w_next = w_mapped ? c_st_setup : c_st_resp;
            c_st_setup:  w_next = c_st_access;
            c_st_access: begin
                if (w_grp_ready || w_expire) begin
                    w_next = (r_abort || !req_sel) ? c_st_idle : c_st_resp;
                end
            end
            c_st_resp:   w_next = req_sel ? c_st_drain : c_st_idle;
            c_st_drain:  if (!req_sel) w_next = c_st_idle;
            default: begin
                w_next      = c_st_idle;
                w_bad_state = 1'b1;
            end
        endcase
    end

    req_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (c_CNT_W)
    ) u_wait_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (r_state == c_st_setup),
        .en     (w_in_access),
        .expire (w_expire)
    );

    // Outputs are loaded from the next state so every output is a plain flop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= c_st_idle;
            r_onehot     <= '0;
            r_abort      <= 1'b0;
            req_ready    <= 1'b0;
            req_rdata    <= '0;
            grp_sel      <= '0;
            grp_enable   <= 1'b0;
            grp_addr     <= '0;
            grp_write    <= 1'b0;
            grp_wdata    <= '0;
            err_unmapped <= 1'b0;
            err_timeout  <= 1'b0;
        end else if (w_bad_state) begin
            r_state      <= c_st_idle;
            r_onehot     <= '0;
            r_abort      <= 1'b0;
            req_ready    <= 1'b0;
            req_rdata    <= '0;
            grp_sel      <= '0;
            grp_enable   <= 1'b0;
            grp_addr     <= '0;
            grp_write    <= 1'b0;
            grp_wdata    <= '0;
            err_unmapped <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == c_st_idle) && req_sel) begin
                r_onehot  <= w_dec;
                r_abort   <= 1'b0;
                grp_addr  <= req_addr[c_LOC_W-1:0];
                grp_write <= req_write;
                grp_wdata <= req_wdata;
            end else if (((r_state == c_st_setup) || w_in_access) && !req_sel) begin
                r_abort <= 1'b1;
            end
            grp_sel    <= ((w_next == c_st_setup) || (w_next == c_st_access)) ? w_sel_src : '0;
            grp_enable <= (w_next == c_st_access);
            req_ready  <= (w_next == c_st_resp);
            if (w_next == c_st_resp) begin
                req_rdata <= w_resp_data;
            end
            err_unmapped <= (r_state == c_st_idle) && req_sel && !w_mapped;
            err_timeout  <= w_in_access && w_expire && !w_grp_ready;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_req_group_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_group_decoder
//  Description : Randomized self-checking bench against a transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_group_decoder;

    logic        clk = 1'b0;
    logic        rstn;
    logic [20:0] req_addr;
    logic        req_write;
    logic        req_sel;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic [15:0] req_rdata;
    logic [3:0]  grp_sel;
    logic        grp_enable;
    logic [15:0] grp_addr;
    logic        grp_write;
    logic [15:0] grp_wdata;
    logic [3:0]  grp_ready;
    logic [63:0] grp_rdata;
    logic        err_unmapped;
    logic        err_timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    req_group_decoder dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_addr     (req_addr),
        .req_write    (req_write),
        .req_sel      (req_sel),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .req_rdata    (req_rdata),
        .grp_sel      (grp_sel),
        .grp_enable   (grp_enable),
        .grp_addr     (grp_addr),
        .grp_write    (grp_write),
        .grp_wdata    (grp_wdata),
        .grp_ready    (grp_ready),
        .grp_rdata    (grp_rdata),
        .err_unmapped (err_unmapped),
        .err_timeout  (err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".req_ready"},    32'(req_ready),    0);
        check({tag, ".req_rdata"},    32'(req_rdata),    0);
        check({tag, ".grp_sel"},      32'(grp_sel),      0);
        check({tag, ".grp_enable"},   32'(grp_enable),   0);
        check({tag, ".grp_addr"},     32'(grp_addr),     0);
        check({tag, ".grp_write"},    32'(grp_write),    0);
        check({tag, ".grp_wdata"},    32'(grp_wdata),    0);
        check({tag, ".err_unmapped"}, 32'(err_unmapped), 0);
        check({tag, ".err_timeout"},  32'(err_timeout),  0);
    endtask

    // Transaction model: group g answers after w wait cycles (w>=64 never answers).
    // Cycle k counts clock edges after the request is first sampled in IDLE.
    task automatic run_txn(input logic [4:0] g, input logic [15:0] loc, input logic wr,
                           input logic [15:0] wd, input logic [15:0] rd,
                           input int w, input int hold, input bit abort);
        int          gi;
        bit          mapped;
        bit          tmo;
        int          k_resp;
        logic [15:0] exp_data;
        logic [3:0]  exp_sel;
        logic [3:0]  nz;
        gi       = int'(g);
        mapped   = (gi < 4);
        tmo      = mapped && (w >= 64);
        k_resp   = !mapped ? 1 : (tmo ? 66 : 3 + w);
        exp_data = (!mapped || tmo) ? 16'hDEAD : rd;
        exp_sel  = mapped ? 4'(1 << gi) : 4'b0000;

        @(negedge clk);
        req_sel   = 1'b1;
        req_addr  = {g, loc};
        req_write = wr;
        req_wdata = wd;
        grp_ready = 4'b0000;
        for (int i = 0; i < 4; i++) grp_rdata[i*16 +: 16] = 16'($urandom);
        if (mapped) grp_rdata[gi*16 +: 16] = rd;

        for (int k = 1; k <= k_resp; k++) begin
            @(negedge clk);
            check("req_ready",    32'(req_ready),    32'(k == k_resp && !abort));
            check("grp_sel",      32'(grp_sel),      32'((mapped && k < k_resp) ? exp_sel : 4'b0000));
            check("grp_enable",   32'(grp_enable),   32'(mapped && k >= 2 && k < k_resp));
            check("err_unmapped", 32'(err_unmapped), 32'(!mapped && k == k_resp));
            check("err_timeout",  32'(err_timeout),  32'(tmo && k == k_resp));
            if (k == k_resp && !abort) check("req_rdata", 32'(req_rdata), 32'(exp_data));
            if (mapped && k == 2) begin
                check("grp_addr",  32'(grp_addr),  32'(loc));
                check("grp_write", 32'(grp_write), 32'(wr));
                check("grp_wdata", 32'(grp_wdata), 32'(wd));
            end
            nz = 4'($urandom);
            if (mapped) begin
                nz[gi] = (k >= 2 && (k - 2) == w);
            end
            grp_ready = nz;
            if (abort && k == 1) req_sel = 1'b0;
        end
        grp_ready = 4'b0000;
        if (!abort) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("drain.req_ready", 32'(req_ready), 0);
                check("drain.grp_sel",   32'(grp_sel),   0);
            end
            req_sel = 1'b0;
        end
    endtask

    initial begin
        logic [4:0] g;
        int         w;
        int         hold;
        bit         abort;

        rstn      = 1'b0;
        req_sel   = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        grp_ready = '0;
        grp_rdata = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        run_txn(5'd2,  16'h0034, 1'b0, 16'h0000, 16'h1234, 0,   0, 1'b0);
        run_txn(5'd0,  16'h0010, 1'b1, 16'hA5A5, 16'h5555, 3,   0, 1'b0);
        run_txn(5'd31, 16'h0000, 1'b0, 16'h0000, 16'h0000, 0,   0, 1'b0);
        run_txn(5'd1,  16'h0100, 1'b0, 16'h0000, 16'hBEEF, 100, 0, 1'b0);
        run_txn(5'd3,  16'h0200, 1'b0, 16'h0000, 16'hC0DE, 63,  0, 1'b0);
        run_txn(5'd1,  16'h0042, 1'b0, 16'h0000, 16'h7777, 1,   3, 1'b0);
        run_txn(5'd2,  16'h0044, 1'b1, 16'h1111, 16'h2222, 0,   0, 1'b0);
        run_txn(5'd4,  16'h0000, 1'b0, 16'h0000, 16'h0000, 0,   2, 1'b0);
        run_txn(5'd0,  16'h0050, 1'b0, 16'h0000, 16'h9999, 2,   0, 1'b1);

        // Asynchronous reset in the middle of an ACCESS to group 3
        @(negedge clk);
        req_sel   = 1'b1;
        req_addr  = {5'd3, 16'h00AA};
        req_write = 1'b0;
        grp_ready = 4'b0000;
        repeat (4) @(negedge clk);
        check("pre_reset.grp_enable", 32'(grp_enable), 1);
        rstn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        req_sel = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        run_txn(5'd3, 16'h00AA, 1'b0, 16'h0000, 16'h3C3C, 1, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            g     = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(4, 31)) : 5'($urandom_range(0, 3));
            w     = ($urandom_range(0, 14) == 0) ? (($urandom_range(0, 1) == 0) ? 63 : 80)
                                                 : int'($urandom_range(0, 6));
            hold  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            abort = (g < 5'd4) && ($urandom_range(0, 7) == 0);
            run_txn(g, 16'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), w, hold, abort);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
